// File: rtl/chameleon_scheduler.sv
// Round-robin sequencing controller for the N-chameleon ring: finds an adjacent
// differing pair, issues it over fire/ack, counts steps and reports termination.
module chameleon_scheduler #(
  parameter int BITS      = 2,
  parameter int N         = 1 << BITS,
  parameter int STEP_W    = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2*N-1:0]    cham_state,
  input  logic              ack,
  output logic [BITS-1:0]   first,
  output logic              fire,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              error,
  output logic [STEP_W-1:0] steps
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_SETTLE, S_DONE, S_TIMEOUT, S_ERROR
  } state_t;

  state_t            state_reg, state_next;
  logic [BITS-1:0]   ptr_reg, ptr_next;
  logic [BITS-1:0]   first_reg, first_next;
  logic [STEP_W-1:0] steps_reg, steps_next;

  logic [N-1:0]      diff_vec;
  logic [N-1:0]      illegal_vec;
  logic [BITS-1:0]   pick_idx;
  logic [BITS-1:0]   cand;

  // diff_vec[i] flags pair (i, i+1 mod N); the wrap pair lives in bit N-1.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pair
      assign illegal_vec[gi] = (cham_state[2*gi +: 2] == 2'd3);
      assign diff_vec[gi]    = (cham_state[2*gi +: 2] != cham_state[2*((gi+1)%N) +: 2]);
    end
  endgenerate

  // Scan downward so the smallest offset from ptr wins; N is a power of two so
  // the BITS-wide add wraps modulo N on its own.
  always_comb begin
    pick_idx = '0;
    cand     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr_reg + BITS'(k);
      if (diff_vec[cand]) begin
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    first_next = first_reg;
    steps_next = steps_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_TIMEOUT, S_ERROR: begin
        if (start) begin
          state_next = S_SCAN;
          steps_next = '0;
        end
      end
      S_SCAN: begin
        if (|illegal_vec) begin
          state_next = S_ERROR;
        end else if (~|diff_vec) begin
          state_next = S_DONE;
        end else if (steps_reg == STEP_W'(MAX_STEPS)) begin
          state_next = S_TIMEOUT;
        end else begin
          first_next = pick_idx;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ack) begin
          if (steps_reg != '1) begin
            steps_next = steps_reg + 1'b1;
          end
          ptr_next   = first_reg + 1'b1;
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: state_next = S_SCAN;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
      first_reg <= '0;
      steps_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      first_reg <= first_next;
      steps_reg <= steps_next;
    end
  end

  assign first   = first_reg;
  assign steps   = steps_reg;
  assign fire    = (state_reg == S_ISSUE);
  assign busy    = (state_reg == S_SCAN) || (state_reg == S_ISSUE) || (state_reg == S_SETTLE);
  assign done    = (state_reg == S_DONE);
  assign timeout = (state_reg == S_TIMEOUT);
  assign error   = (state_reg == S_ERROR);

endmodule

// File: doc/chameleon_scheduler.md
Name: chameleon_scheduler

Overview:
- Sequencing controller for the N-chameleon ring datapath.
- Replaces the free nondeterministic pair choice with a deterministic, fair round-robin scheduler.
- Scans the ring's colour vector for an adjacent differing pair, issues its lower index to the datapath over a fire/ack handshake, and counts steps.
- Reports stable, timeout or illegal-encoding termination.

Parameters:
- BITS, 2, log2 of ring size.
- N, 1<<BITS, number of chameleons.
- STEP_W, 8, width of the step counter.
- MAX_STEPS, 255, step budget; hitting it before stability gives timeout.

Ports:
- clock  input  1  Sole clock; all state updates on posedge.
- reset  input  1  Synchronous, active-high reset.
- start  input  1  Begin a run. Honoured only in IDLE, DONE, TIMEOUT or ERROR.
- cham_state  input  2*N  Current datapath colours. Element i is bits [2i+1:2i]. RED=0, GREEN=1, BLUE=2; 3 is illegal.
- ack  input  1  Datapath accepted the issued pair this cycle.
- first  output  BITS  Index of the issued pair's lower element. The pair is (first, first+1 mod N).
- fire  output  1  Issue request valid.
- busy  output  1  High in SCAN, ISSUE and SETTLE.
- done  output  1  Ring is stable (all colours equal).
- timeout  output  1  Step budget exhausted.
- error  output  1  Illegal colour code detected.
- steps  output  STEP_W  Acknowledged steps in the current run.

Behaviour:
- Reset, sync, any state, including mid-handshake:
  - state=IDLE, ptr=0, first=0.
  - fire, busy, done, timeout, error = 0; steps=0.
- States: IDLE, SCAN, ISSUE, SETTLE, DONE, TIMEOUT, ERROR.
- IDLE/DONE/TIMEOUT/ERROR with start=1:
  - Next state SCAN; steps cleared to 0.
  - done, timeout and error cleared.
  - ptr is kept, not reset.
- SCAN (exactly one cycle), evaluated on the registered-in-cycle cham_state, in this priority order:
  - Any element ==3 -> ERROR; error=1.
  - Else all adjacent pairs equal -> DONE; done=1. Done takes precedence over timeout.
  - Else steps==MAX_STEPS -> TIMEOUT; timeout=1.
  - Else search k=0..N-1 for the first index j=(ptr+k) mod N with cham[j]!=cham[(j+1) mod N]. Latch first=j and go to ISSUE.
  - Wrap pair (N-1, 0) is included.
- ISSUE:
  - fire=1. first is held stable while fire=1 && ack=0; there is no timeout on ack.
  - On a posedge with fire&&ack: steps+=1 (saturating at all ones), ptr=(first+1) mod N, go to SETTLE.
- SETTLE:
  - One cycle, fire=0, so the datapath's colour update is visible.
  - Then go to SCAN.
- ack outside ISSUE is ignored.
- start outside terminal/IDLE states is ignored.
- Latency:
  - start -> SCAN is 1 cycle.
  - SCAN -> fire is 1 cycle.
  - ack -> next fire is at least 3 cycles (SETTLE, SCAN, ISSUE).
  - start -> done on a stable ring is 2 cycles.
- Fairness: advancing ptr past the served pair guarantees every persistently differing pair is served within N issues.
- Terminal flags hold until the next start or reset.

Test Plan:
- Stable ring: reset, cham=[R,R,R,R], start -> SCAN, then done=1 two cycles after start; fire never asserted; steps=0.
- One-step convergence: cham=[R,G,B,B] (index 0 first), start -> fire with first=0.
  - Model ack, datapath sets [B,B,B,B] -> done=1, steps=1, ptr=1.
- Rotation and timeout: MAX_STEPS=3, cham=[R,R,G,G], bench applies datapath rule on each ack.
  - Issued first sequence is 1, 2, 0.
  - Then timeout=1, steps=3, done=0.
- Ack stall: hold ack=0 for 5 cycles in ISSUE -> fire=1 and first constant throughout; steps unchanged.
  - ack=1 -> steps+1; fire low the following cycle.
- Illegal code: cham element 2 = 3, start -> error=1 after SCAN; fire never asserted.
  - A new start with legal colours clears error.
- Reset mid-handshake: assert reset during ISSUE with ack=0 -> next cycle all outputs 0 and state IDLE.
  - A later start on [R,G,B,B] issues first=0 (ptr cleared).
